// File: rtl/sprite_mover.sv
// Sprite mover: erases the sprite at its old position, steps the centre by STEP
// with screen clamping, then redraws it from a sprite ROM, one pixel per clock.
module sprite_mover #(
  parameter int          nX           = 10,
  parameter int          nY           = 9,
  parameter int          xOBJ         = 4,
  parameter int          yOBJ         = 4,
  parameter int          XOFFSET      = 320,
  parameter int          YOFFSET      = 240,
  parameter int          STEP         = 4,
  parameter int          XRES         = 640,
  parameter int          YRES         = 480,
  parameter logic [8:0]  BG_COLOR     = 9'h000,
  parameter bit          TRANSP_EN    = 1'b0,
  parameter logic [8:0]  TRANSP_COLOR = 9'h1FF
) (
  input  logic                 CLOCK_50,
  input  logic                 Resetn,
  input  logic                 go,
  input  logic                 move,
  input  logic [1:0]           dir,
  output logic [xOBJ+yOBJ-1:0] rom_addr,
  input  logic [8:0]           rom_data,
  output logic [nX-1:0]        VGA_x,
  output logic [nY-1:0]        VGA_y,
  output logic [8:0]           VGA_color,
  output logic                 VGA_write,
  output logic                 done,
  output logic                 busy,
  output logic [nX-1:0]        pos_x,
  output logic [nY-1:0]        pos_y,
  output logic [2:0]           fsm_state
);

  localparam int BX = 1 << xOBJ;
  localparam int BY = 1 << yOBJ;
  localparam int AW = xOBJ + yOBJ;

  localparam logic [nX:0]   X_MIN  = (nX+1)'(BX / 2);
  localparam logic [nX:0]   X_MAX  = (nX+1)'(XRES - BX / 2);
  localparam logic [nX:0]   X_STEP = (nX+1)'(STEP);
  localparam logic [nY:0]   Y_MIN  = (nY+1)'(BY / 2);
  localparam logic [nY:0]   Y_MAX  = (nY+1)'(YRES - BY / 2);
  localparam logic [nY:0]   Y_STEP = (nY+1)'(STEP);
  localparam logic [nX-1:0] HALF_X = nX'(BX / 2);
  localparam logic [nY-1:0] HALF_Y = nY'(BY / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_n;

  logic          go_q;
  logic          go_rise;
  logic [AW-1:0] cnt;
  logic          last_px;
  logic          issue;
  logic          erase_ph;
  logic [nX-1:0] tgt_x;
  logic [nY-1:0] tgt_y;
  logic [nX:0]   px_w, tgt_x_c;
  logic [nY:0]   py_w, tgt_y_c;
  logic          same_pos;
  logic [nX-1:0] pix_x;
  logic [nY-1:0] pix_y;
  logic          p1_valid;
  logic          p1_erase;
  logic [nX-1:0] p1_x;
  logic [nY-1:0] p1_y;

  // go/move are plain level/pulse requests with no ready: they are acted on only
  // in IDLE (busy=0) and dropped otherwise; done pulses once per accepted request.
  assign go_rise  = go & ~go_q;
  assign last_px  = &cnt;
  assign rom_addr = cnt;
  assign fsm_state = state;

  // Target is formed one bit wider than the coordinate and clamped, so it never wraps.
  assign px_w = {1'b0, pos_x};
  assign py_w = {1'b0, pos_y};

  always_comb begin
    tgt_x_c = px_w;
    tgt_y_c = py_w;
    case (dir)
      2'b00: tgt_x_c = (px_w < X_MIN + X_STEP) ? X_MIN : px_w - X_STEP;
      2'b01: tgt_y_c = (py_w < Y_MIN + Y_STEP) ? Y_MIN : py_w - Y_STEP;
      2'b10: tgt_y_c = (py_w + Y_STEP > Y_MAX) ? Y_MAX : py_w + Y_STEP;
      default: tgt_x_c = (px_w + X_STEP > X_MAX) ? X_MAX : px_w + X_STEP;
    endcase
  end

  assign same_pos = (tgt_x_c == px_w) && (tgt_y_c == py_w);

  // Pixel address is {YC,XC}: XC runs fastest, giving row-major order.
  assign pix_x = pos_x - HALF_X + nX'(cnt[xOBJ-1:0]);
  assign pix_y = pos_y - HALF_Y + nY'(cnt[AW-1:xOBJ]);

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (go_rise)   state_n = S_DRAW;
        else if (move) state_n = same_pos ? S_DONE : S_ERASE;
      end
      S_ERASE:  if (last_px) state_n = S_UPDATE;
      S_UPDATE: state_n = S_DRAW;
      S_DRAW:   if (last_px) state_n = S_FLUSH;
      S_FLUSH:  if (cnt[0])  state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    issue    = (state == S_ERASE) || (state == S_DRAW);
    erase_ph = (state == S_ERASE);
  end

  // cnt walks the pixels in ERASE/DRAW, wraps to 0 on the last one, then times FLUSH.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      go_q  <= 1'b1;
      cnt   <= '0;
      pos_x <= nX'(XOFFSET);
      pos_y <= nY'(YOFFSET);
      tgt_x <= nX'(XOFFSET);
      tgt_y <= nY'(YOFFSET);
    end else begin
      go_q <= go;
      cnt  <= (issue || state == S_FLUSH) ? cnt + 1'b1 : '0;
      if (state == S_IDLE) begin
        tgt_x <= tgt_x_c[nX-1:0];
        tgt_y <= tgt_y_c[nY-1:0];
      end
      if (state == S_UPDATE) begin
        pos_x <= tgt_x;
        pos_y <= tgt_y;
      end
    end
  end

  // Two-stage pixel pipe: stage 1 waits for the ROM read, stage 2 drives the VGA port.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      p1_valid  <= 1'b0;
      p1_erase  <= 1'b0;
      p1_x      <= '0;
      p1_y      <= '0;
      VGA_x     <= '0;
      VGA_y     <= '0;
      VGA_color <= '0;
      VGA_write <= 1'b0;
    end else begin
      p1_valid  <= issue;
      p1_erase  <= erase_ph;
      p1_x      <= pix_x;
      p1_y      <= pix_y;
      VGA_x     <= p1_x;
      VGA_y     <= p1_y;
      VGA_color <= p1_erase ? BG_COLOR : rom_data;
      VGA_write <= p1_valid &&
                   (p1_erase || !(TRANSP_EN && (rom_data == TRANSP_COLOR)));
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: a scoreboard of expected pixel writes built from a
// bench-side position model, plus latency, position, reset and clamp checks.
module tb_sprite_mover;

  localparam int N = 256;
  localparam int W = 28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go, move;
  logic [1:0] dir;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
  logic [9:0] VGA_x;
  logic [8:0] VGA_y;
  logic [8:0] VGA_color;
  logic       VGA_write, done, busy;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic [2:0] fsm_state;

  logic       e_go, e_move;
  logic [1:0] e_dir;
  logic [7:0] e_rom_addr;
  logic [8:0] e_rom_data;
  logic [9:0] e_vga_x;
  logic [8:0] e_vga_y;
  logic [8:0] e_vga_color;
  logic       e_write, e_done, e_busy;
  logic [9:0] e_pos_x;
  logic [8:0] e_pos_y;
  logic [2:0] e_state;

  logic [8:0]   rom_mem [0:N-1];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int e_wr_cnt = 0;
  int exp_writes = 0;
  int mx = 320;
  int my = 240;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sprite_mover #(.TRANSP_EN(1'b1)) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .go(go), .move(move), .dir(dir),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
    .done(done), .busy(busy), .pos_x(pos_x), .pos_y(pos_y), .fsm_state(fsm_state)
  );

  sprite_mover #(.XOFFSET(10)) dut_e (
    .CLOCK_50(clk), .Resetn(rst_n), .go(e_go), .move(e_move), .dir(e_dir),
    .rom_addr(e_rom_addr), .rom_data(e_rom_data),
    .VGA_x(e_vga_x), .VGA_y(e_vga_y), .VGA_color(e_vga_color), .VGA_write(e_write),
    .done(e_done), .busy(e_busy), .pos_x(e_pos_x), .pos_y(e_pos_y), .fsm_state(e_state)
  );

  always @(posedge clk) begin
    rom_data   <= rom_mem[rom_addr];
    e_rom_data <= rom_mem[e_rom_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && VGA_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("pixel", {VGA_x, VGA_y, VGA_color}, mon_e);
      end
    end
    if (rst_n === 1'b1 && e_write === 1'b1) e_wr_cnt++;
  end

  task automatic push_sprite(input int cx, input int cy, input logic erase);
    logic [8:0] c;
    for (int yc = 0; yc < 16; yc++) begin
      for (int xc = 0; xc < 16; xc++) begin
        c = erase ? 9'h000 : rom_mem[yc * 16 + xc];
        if (erase || c != 9'h1FF) begin
          exp_q.push_back({10'(cx - 8 + xc), 9'(cy - 8 + yc), c});
          exp_writes++;
        end
      end
    end
  endtask

  task automatic model_target(input logic [1:0] d, output int nx, output int ny);
    nx = mx;
    ny = my;
    case (d)
      2'd0: nx = mx - 4;
      2'd1: ny = my - 4;
      2'd2: ny = my + 4;
      default: nx = mx + 4;
    endcase
    if (nx < 8) nx = 8;
    if (nx > 632) nx = 632;
    if (ny < 8) ny = 8;
    if (ny > 472) ny = 472;
  endtask

  // ---------------- drivers ----------------
  task automatic do_op(input logic use_go, input logic use_move, input logic [1:0] d,
                       input int inject_at);
    int nx, ny, exp_lat, n;
    nx = mx;
    ny = my;
    exp_writes = 0;
    if (use_go) begin
      push_sprite(mx, my, 1'b0);
      exp_lat = N + 3;
    end else begin
      model_target(d, nx, ny);
      if (nx == mx && ny == my) exp_lat = 1;
      else begin
        push_sprite(mx, my, 1'b1);
        push_sprite(nx, ny, 1'b0);
        exp_lat = 2 * N + 4;
      end
    end
    wr_cnt = 0;
    @(negedge clk);
    go = use_go; move = use_move; dir = d;
    @(negedge clk);
    go = 1'b0; move = 1'b0;
    check("busy_c1", busy, 1);
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      if (!use_go && exp_lat > 1 && n == 2) check("no_write_c2", VGA_write, 0);
      if (!use_go && exp_lat > 1 && n == 3) check("first_write_c3", VGA_write, 1);
      if (n == inject_at) begin move = 1'b1; dir = 2'($urandom_range(0, 3)); end
      else move = 1'b0;
      @(negedge clk);
      n++;
    end
    move = 1'b0;
    check("done_latency", n, exp_lat);
    mx = nx;
    my = ny;
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_after", busy, 0);
    repeat (4) @(negedge clk);
    check("wr_count", wr_cnt, exp_writes);
    check("queue_empty", exp_q.size(), 0);
    check("pos_x", pos_x, mx);
    check("pos_y", pos_y, my);
  endtask

  task automatic reset_mid(input int at, input logic [1:0] d);
    int nx, ny;
    model_target(d, nx, ny);
    exp_writes = 0;
    push_sprite(mx, my, 1'b1);
    push_sprite(nx, ny, 1'b0);
    @(negedge clk);
    move = 1'b1; dir = d;
    @(negedge clk);
    move = 1'b0;
    for (int n = 1; n < at; n++) @(negedge clk);
    check("write_before_rst", VGA_write, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_write", VGA_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pos_x", pos_x, 320);
    check("rst_pos_y", pos_y, 240);
    check("rst_state", fsm_state, 0);
    exp_q.delete();
    mx = 320;
    my = 240;
    repeat (3) @(negedge clk);
    check("rst_hold_write", VGA_write, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic e_move_left(input int exp_lat, input int exp_x, input int exp_wr);
    int n;
    e_wr_cnt = 0;
    @(negedge clk);
    e_move = 1'b1; e_dir = 2'd0;
    @(negedge clk);
    e_move = 1'b0;
    n = 1;
    while (e_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("e_done_latency", n, exp_lat);
    repeat (4) @(negedge clk);
    check("e_pos_x", e_pos_x, exp_x);
    check("e_pos_y", e_pos_y, 240);
    check("e_wr_count", e_wr_cnt, exp_wr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) rom_mem[i] = 9'($urandom_range(0, 510));
    go = 1'b0; move = 1'b0; dir = 2'd0;
    e_go = 1'b0; e_move = 1'b0; e_dir = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vga_x", VGA_x, 0);
    check("reset_vga_y", VGA_y, 0);
    check("reset_color", VGA_color, 0);
    check("reset_write", VGA_write, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_pos_x", pos_x, 320);
    check("reset_pos_y", pos_y, 240);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b1, 1'b0, 2'd0, 0);      // draw in place
    do_op(1'b0, 1'b1, 2'd3, 0);      // right
    do_op(1'b0, 1'b1, 2'd1, 0);      // up
    do_op(1'b0, 1'b1, 2'd2, 0);      // down
    do_op(1'b0, 1'b1, 2'd0, 0);      // left
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b1, 2'($urandom_range(0, 3)), 0);
    do_op(1'b1, 1'b1, 2'd3, 0);      // go wins over move
    do_op(1'b1, 1'b0, 2'd0, 100);    // move during DRAW ignored

    reset_mid(100, 2'd3);            // mid-ERASE
    reset_mid(300, 2'd3);            // mid-DRAW, pos already updated

    // go held high through reset must not start a draw
    wr_cnt = 0;
    rst_n = 1'b0;
    #1 go = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("go_held_busy", busy, 0);
    check("go_held_writes", wr_cnt, 0);
    go = 1'b0;
    @(negedge clk);

    e_move_left(2 * N + 4, 8, 2 * N); // clamp from 10 to 8
    e_move_left(1, 8, 0);             // already at left edge

    for (int i = 0; i < 40; i++) rom_mem[i * 6] = 9'h1FF;
    do_op(1'b1, 1'b0, 2'd0, 0);
    check("transp_writes", wr_cnt, 216);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter nX, default 10: VGA x-coordinate width.
REQ-002 SHALL have parameter nY, default 9: VGA y-coordinate width.
REQ-003 SHALL have parameters xOBJ and yOBJ, default 4 and 4: sprite size is BX=2^xOBJ by BY=2^yOBJ, with N=BX*BY pixels.
REQ-004 SHALL have parameters XOFFSET and YOFFSET, default 320 and 240: initial sprite centre; both SHALL lie within the clamp window.
REQ-005 SHALL have parameter STEP, default 4: pixels moved per move command.
REQ-006 SHALL have parameters XRES and YRES, default 640 and 480: screen size used for clamping.
REQ-007 SHALL have parameter BG_COLOR, default 9'h000: erase colour.
REQ-008 SHALL have parameters TRANSP_EN, default 0, and TRANSP_COLOR, default 9'h1FF: skip writing pixels of this colour.
REQ-009 Clock  in  1  single system clock; all logic on its rising edge.
REQ-010 Resetn  in  1  asynchronous, active-low reset.
REQ-011 go  in  1  level input; its rising edge requests a draw at the current position with no erase.
REQ-012 move  in  1  one-cycle pulse requesting a step in direction dir.
REQ-013 dir  in  2  direction: 00 left, 01 up, 10 down, 11 right.
REQ-014 rom_addr  out  xOBJ+yOBJ  sprite ROM address {YC,XC}.
REQ-015 rom_data  in  9  ROM pixel, valid one cycle after rom_addr.
REQ-016 VGA_x / VGA_y  out  nX / nY  pixel coordinate.
REQ-017 VGA_color  out  9  pixel colour.
REQ-018 VGA_write  out  1  pixel write strobe.
REQ-019 done  out  1  one-cycle pulse marking completion of a request.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 pos_x / pos_y  out  nX / nY  current sprite centre.

Function
REQ-022 FSM states SHALL be IDLE, ERASE, UPDATE, DRAW, FLUSH (2 cycles) and DONE.
REQ-023 In IDLE, a go rising edge SHALL go to DRAW; otherwise move SHALL go to UPDATE-check; go SHALL win when both occur in the same cycle.
REQ-024 go and move SHALL be ignored while busy=1; requests SHALL NOT be queued.
REQ-025 Target position SHALL be computed in nX+1 / nY+1 bits and clamped to x in [BX/2, XRES-BX/2] and y in [BY/2, YRES-BY/2]; it SHALL never wrap.
REQ-026 For a move whose clamped target equals the current position, the FSM SHALL go IDLE->DONE, with no VGA_write and done one cycle after move is sampled.
REQ-027 Otherwise: ERASE for N cycles, then UPDATE for 1 cycle (pos loaded with the target), then DRAW for N cycles, FLUSH, DONE, IDLE.
REQ-028 ERASE and DRAW SHALL each issue one pixel per cycle, row-major with XC fastest; pixel coordinate = (pos - B/2) + (XC,YC).
REQ-029 Pipeline: a pixel issued in cycle k SHALL appear on VGA_* in cycle k+2; VGA_x, VGA_y, VGA_color and VGA_write SHALL be aligned in the same cycle.
REQ-030 ERASE pixels SHALL use the pre-UPDATE position and colour BG_COLOR, with VGA_write=1 for every pixel.
REQ-031 DRAW pixels SHALL use colour rom_data; VGA_write SHALL be 0 for a pixel when TRANSP_EN=1 and rom_data==TRANSP_COLOR.
REQ-032 Timing for a move sampled in cycle 0: first VGA_write in cycle 3, done in cycle 2N+4.
REQ-033 Timing for a go edge sampled in cycle 0: DRAW in cycles 1..N, done in cycle N+3.
REQ-034 VGA_write SHALL be 0 outside the ERASE/DRAW pipeline window.

Reset
REQ-035 Resetn=0 SHALL immediately force: state IDLE; VGA_x, VGA_y, VGA_color, VGA_write, done, busy and rom_addr to 0; pos_x=XOFFSET and pos_y=YOFFSET.
REQ-036 Reset asserted mid-ERASE or mid-DRAW SHALL abort the operation with no further writes.
REQ-037 The go edge detector SHALL reset to "previous go = 1", so a go held high through reset does not trigger a draw.

Verification
REQ-038 Defaults, go pulsed at cycle 0 -> 256 writes with x 312..327 and y 232..247, colour = ROM contents, done at cycle 259.
REQ-039 Move right from (320,240) -> 256 writes of 9'h000 at x 312..327, then 256 ROM writes at x 316..331, pos_x=324, done at cycle 516.
REQ-040 XOFFSET=10: move left -> pos_x=8 with a full erase and draw; a second move left -> no VGA_write and done at cycle 1.
REQ-041 TRANSP_EN=1 with a ROM containing 40 pixels equal to 9'h1FF -> draw phase produces exactly 216 writes.
REQ-042 Move pulsed during DRAW -> ignored, with exactly one done; go and move in the same IDLE cycle -> draw only, no erase.
REQ-043 Resetn low at cycle 100 of a move -> VGA_write=0 and busy=0 in the same cycle, and pos returns to (320,240).
